// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: op/state types and width-generic sign helpers for the muldiv unit
package mips_cpu_muldiv_pkg;
  localparam int MAXW = 128;
  localparam int IW = $clog2(MAXW);
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  // Callers zero-extend into MAXW bits and size-cast the result back to their width
  function automatic logic [MAXW-1:0] neg_w(input logic [MAXW-1:0] x);
    return ~x + MAXW'(1);
  endfunction
  function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] x, input int w);
    return x[IW'(w - 1)] ? neg_w(x) : x;
  endfunction
endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: control-unit request and HI/LO result bundle for the muldiv unit
interface mips_cpu_muldiv_if import mips_cpu_muldiv_pkg::*; #(parameter int WIDTH = 32);
  logic start;
  muldiv_op_t op;
  logic [WIDTH-1:0] a, b;
  logic busy, done;
  logic [WIDTH-1:0] hi, lo;
  modport master(output start, op, a, b, input busy, done, hi, lo);
  modport slave(input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative radix-2 multiply/divide unit owning the HI/LO registers
module mips_cpu_muldiv import mips_cpu_muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mips_cpu_muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [W2:0] acc, mul_nx, sh, div_nx;
  logic [WIDTH-1:0] m, hi, lo, ma, mb, q, r;
  logic [WIDTH:0] sum;
  logic [WIDTH+1:0] dif;
  logic [W2-1:0] prod;
  logic neg_q, neg_r, dz, is_mul, busy, done, sg, sa, sb, op_mul;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi = hi;
  assign bus.lo = lo;
  always_comb begin
    sum = acc[W2:WIDTH] + {1'b0, m};
    mul_nx = {1'b0, acc[0] ? sum : acc[W2:WIDTH], acc[WIDTH-1:1]};
    sh = {acc[W2-1:0], 1'b0};
    dif = {1'b0, sh[W2:WIDTH]} - {2'b0, m};
    // Restoring step: keep the shifted remainder when the trial subtract borrows
    div_nx = dif[WIDTH+1] ? sh : {dif[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    sg = bus.op == OP_MULT || bus.op == OP_DIV;
    sa = sg && bus.a[WIDTH-1];
    sb = sg && bus.b[WIDTH-1];
    op_mul = !bus.op[1];
    ma = sg ? WIDTH'(abs_w(MAXW'(bus.a), WIDTH)) : bus.a;
    mb = sg ? WIDTH'(abs_w(MAXW'(bus.b), WIDTH)) : bus.b;
    prod = neg_q ? W2'(neg_w(MAXW'(acc[W2-1:0]))) : acc[W2-1:0];
    q = neg_q ? WIDTH'(neg_w(MAXW'(acc[WIDTH-1:0]))) : acc[WIDTH-1:0];
    r = neg_r ? WIDTH'(neg_w(MAXW'(acc[W2-1:WIDTH]))) : acc[W2-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      busy <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          if (bus.op == OP_MTHI) hi <= bus.a;
          if (bus.op == OP_MTLO) lo <= bus.a;
          if (!bus.op[2]) begin
            state <= op_mul ? S_MUL : S_DIV;
            acc <= {{(WIDTH + 1){1'b0}}, op_mul ? mb : ma};
            m <= op_mul ? ma : mb;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= !op_mul && bus.b == '0;
            is_mul <= op_mul;
            cnt <= CW'(WIDTH);
            busy <= 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          acc <= state == S_MUL ? mul_nx : div_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          hi <= is_mul ? prod[W2-1:WIDTH] : r;
          lo <= is_mul ? prod[WIDTH-1:0] : dz ? '1 : q;
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
